// File: rtl/mole_spawner.sv
// Whack-a-mole round controller: spawns moles on 8 slots, times their lives,
// scores whacks and misses, and ends the round on timeout or too many misses.
// Ports:
//   game_clk, rst       clock and synchronous active-high reset
//   start               level; starts a round from IDLE or OVER (ignored in PLAY)
//   rand_byte[7:0]      random byte, bits [2:0] pick the spawn slot
//                       (the port cannot be called "rand", which is a reserved word)
//   sw[7:0]             raw player switches; any edge on bit i whacks slot i
//   led[7:0]            lit moles
//   hit_count[3:0]      moles whacked in the previous cycle (one-cycle pulse value)
//   miss_count[3:0]     moles expired this round, saturating at 15
//   time_left[11:0]     remaining round cycles
//   state[1:0]          IDLE=0, PLAY=1, OVER=2
// All outputs come straight from registers.
module mole_spawner #(
    parameter int LIFE_TICKS  = 50,
    parameter int SPAWN_GAP   = 25,
    parameter int ROUND_TICKS = 3000,
    parameter int MAX_MISSES  = 5
) (
    input  logic        game_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rand_byte,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic [3:0]  hit_count,
    output logic [3:0]  miss_count,
    output logic [11:0] time_left,
    output logic [1:0]  state
);

    localparam int LW = $clog2(LIFE_TICKS + 1);
    localparam int SW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    localparam logic [LW-1:0] LIFE_INIT  = LW'(LIFE_TICKS);
    localparam logic [LW-1:0] LIFE_ONE   = LW'(1);
    localparam logic [SW-1:0] GAP_LAST   = SW'(SPAWN_GAP - 1);
    localparam logic [SW-1:0] GAP_ONE    = SW'(1);
    localparam logic [11:0]   ROUND_INIT = 12'(ROUND_TICKS);
    localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISSES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;

    logic [7:0]    sw_prev;
    logic [SW-1:0] spawn_cnt;
    logic [LW-1:0] life [8];

    logic [7:0]    led_n;
    logic [3:0]    hit_n;
    logic [3:0]    miss_n;
    logic [11:0]   time_n;
    logic [SW-1:0] spawn_n;
    logic [LW-1:0] life_n [8];

    logic [7:0]    toggle;
    logic [7:0]    hits;
    logic [7:0]    expire;
    logic [2:0]    slot;
    logic          spawn_now;
    logic [4:0]    miss_sum;
    logic          unused_rand;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    assign state       = cur_state;
    assign slot        = rand_byte[2:0];
    assign unused_rand = ^rand_byte[7:3];
    assign toggle      = sw ^ sw_prev;
    assign hits        = toggle & led;
    assign spawn_now   = (spawn_cnt == GAP_LAST);

    // A hit on a slot whose life is running out takes precedence: no miss.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            expire[i] = led[i] && (life[i] == LIFE_ONE) && !hits[i];
        end
    end

    assign miss_sum = {1'b0, miss_count} + {1'b0, popcount8(expire)};

    always_ff @(posedge game_clk) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        led_n     = led;
        hit_n     = 4'd0;
        miss_n    = miss_count;
        time_n    = time_left;
        spawn_n   = spawn_cnt;
        life_n    = life;

        case (cur_state)
            PLAY: begin
                time_n  = time_left - 12'd1;
                spawn_n = spawn_now ? '0 : spawn_cnt + GAP_ONE;
                miss_n  = (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];
                hit_n   = popcount8(hits);

                for (int i = 0; i < 8; i++) begin
                    if (hits[i] || expire[i]) begin
                        led_n[i]  = 1'b0;
                        life_n[i] = '0;
                    end else if (led[i]) begin
                        life_n[i] = life[i] - LIFE_ONE;
                    end
                end

                // Occupancy is judged on the registered led, so a spawn onto a
                // slot being hit or expiring this cycle is dropped.
                if (spawn_now && !led[slot]) begin
                    led_n[slot]  = 1'b1;
                    life_n[slot] = LIFE_INIT;
                end

                // miss_count here is the registered value, so the round ends
                // one cycle after the limit becomes visible.
                if ((time_left <= 12'd1) || (miss_count >= MISS_LIMIT)) begin
                    nxt_state = OVER;
                    led_n     = 8'h00;
                    hit_n     = 4'd0;
                end
            end

            IDLE, OVER: begin
                led_n = 8'h00;
                if (start) begin
                    nxt_state = PLAY;
                    miss_n    = 4'd0;
                    time_n    = ROUND_INIT;
                    spawn_n   = '0;
                    for (int i = 0; i < 8; i++) begin
                        life_n[i] = '0;
                    end
                end
            end

            default: begin
                nxt_state = IDLE;
                led_n     = 8'h00;
            end
        endcase
    end

    always_ff @(posedge game_clk) begin
        sw_prev <= sw;
        if (rst) begin
            led        <= 8'h00;
            hit_count  <= 4'd0;
            miss_count <= 4'd0;
            time_left  <= 12'd0;
            spawn_cnt  <= '0;
            for (int i = 0; i < 8; i++) begin
                life[i] <= '0;
            end
        end else begin
            led        <= led_n;
            hit_count  <= hit_n;
            miss_count <= miss_n;
            time_left  <= time_n;
            spawn_cnt  <= spawn_n;
            for (int i = 0; i < 8; i++) begin
                life[i] <= life_n[i];
            end
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with LIFE_TICKS=4, SPAWN_GAP=3,
// ROUND_TICKS=20, MAX_MISSES=2. Cycle c counts PLAY cycles from 0, the first
// cycle that shows state=PLAY; spawns are sampled in cycles 2, 5, 8, ...
module tb_mole_spawner;

    logic        game_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rand_byte;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;
    logic [11:0] time_left;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    mole_spawner #(
        .LIFE_TICKS (4),
        .SPAWN_GAP  (3),
        .ROUND_TICKS(20),
        .MAX_MISSES (2)
    ) dut (
        .game_clk  (game_clk),
        .rst       (rst),
        .start     (start),
        .rand_byte (rand_byte),
        .sw        (sw),
        .led       (led),
        .hit_count (hit_count),
        .miss_count(miss_count),
        .time_left (time_left),
        .state     (state)
    );

    always #5 game_clk = ~game_clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge game_clk);
            #1;
        end
    endtask

    // Leaves the bench observing PLAY cycle 0.
    task automatic begin_round(input logic [7:0] r);
        rst = 1'b1; start = 1'b0; rand_byte = r;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rand_byte = 8'h00; sw = 8'h00;
        tick(2);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
        checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL reset_hit: got %0d expected 0", hit_count); end
        checks++; if (miss_count !== 4'd0) begin errors++; $display("FAIL reset_miss: got %0d expected 0", miss_count); end
        checks++; if (time_left !== 12'd0) begin errors++; $display("FAIL reset_time: got %0d expected 0", time_left); end
        rst = 1'b0;
        tick(3);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state); end
    endtask

    // Slot 0 is whacked continuously so no miss happens; start pulses mid-round
    // must not restart the countdown.
    task automatic test_round_timeout();
        logic [11:0] exp_t;
        logic [1:0]  exp_s;
        rand_byte = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
        checks++; if (time_left !== 12'd20) begin errors++; $display("FAIL start_time: got %0d expected 20", time_left); end
        for (int k = 1; k <= 20; k++) begin
            sw    = sw ^ 8'h01;
            start = (k == 5 || k == 6);
            tick();
            exp_t = 12'(20 - k);
            exp_s = (k < 20) ? 2'd1 : 2'd2;
            checks++; if (time_left !== exp_t) begin errors++; $display("FAIL countdown_time c%0d: got %0d expected %0d", k, time_left, exp_t); end
            checks++; if (state !== exp_s) begin errors++; $display("FAIL countdown_state c%0d: got %0d expected %0d", k, state, exp_s); end
        end
        start = 1'b0;
        checks++; if (miss_count !== 4'd0) begin errors++; $display("FAIL timeout_miss: got %0d expected 0", miss_count); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL timeout_led: got %h expected 00", led); end
        tick(2);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL over_hold_state: got %0d expected 2", state); end
        checks++; if (time_left !== 12'd0) begin errors++; $display("FAIL over_hold_time: got %0d expected 0", time_left); end
    endtask

    // Cycle 5 also carries a spawn attempt on the slot being hit: dropped.
    task automatic test_single_hit();
        begin_round(8'h05);
        tick(3);
        checks++; if (led !== 8'h20) begin errors++; $display("FAIL spawn_led: got %h expected 20", led); end
        tick(2);
        sw = sw ^ 8'h20;
        tick();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL hit_led: got %h expected 00", led); end
        checks++; if (hit_count !== 4'd1) begin errors++; $display("FAIL hit_count: got %0d expected 1", hit_count); end
        tick();
        checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL hit_pulse: got %0d expected 0", hit_count); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL hit_spawn_drop: got %h expected 00", led); end
    endtask

    // Slot 3 lit at c3; the c5 spawn on it is dropped without reloading life.
    task automatic test_miss();
        begin_round(8'h03);
        tick(3);
        checks++; if (led !== 8'h08) begin errors++; $display("FAIL miss_lit: got %h expected 08", led); end
        tick(3);
        checks++; if (led !== 8'h08) begin errors++; $display("FAIL relit_unchanged: got %h expected 08", led); end
        checks++; if (miss_count !== 4'd0) begin errors++; $display("FAIL pre_miss: got %0d expected 0", miss_count); end
        tick();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL expire_led: got %h expected 00", led); end
        checks++; if (miss_count !== 4'd1) begin errors++; $display("FAIL miss_one: got %0d expected 1", miss_count); end
        tick(6);
        checks++; if (miss_count !== 4'd2) begin errors++; $display("FAIL miss_two: got %0d expected 2", miss_count); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL miss_limit_state: got %0d expected 1", state); end
        checks++; if (time_left !== 12'd7) begin errors++; $display("FAIL miss_limit_time: got %0d expected 7", time_left); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL miss_over: got %0d expected 2", state); end
        checks++; if (miss_count !== 4'd2) begin errors++; $display("FAIL over_miss_hold: got %0d expected 2", miss_count); end
        tick();
        checks++; if (time_left !== 12'd6) begin errors++; $display("FAIL over_time_hold: got %0d expected 6", time_left); end
    endtask

    // Slot 1 is on its last life cycle when hit: the hit wins, no miss.
    task automatic test_multi_hit();
        begin_round(8'h01);
        tick(3);
        rand_byte = 8'h06;
        tick(3);
        checks++; if (led !== 8'h42) begin errors++; $display("FAIL two_lit: got %h expected 42", led); end
        sw = sw ^ 8'h43;
        tick();
        checks++; if (hit_count !== 4'd2) begin errors++; $display("FAIL multi_hit: got %0d expected 2", hit_count); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL multi_hit_led: got %h expected 00", led); end
        checks++; if (miss_count !== 4'd0) begin errors++; $display("FAIL hit_beats_expire: got %0d expected 0", miss_count); end
        tick();
        checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL multi_pulse: got %0d expected 0", hit_count); end
    endtask

    // Continues the round above from c8 up to c15, then resets mid-PLAY.
    task automatic test_reset_mid();
        tick(7);
        checks++; if (led !== 8'h40) begin errors++; $display("FAIL mid_led: got %h expected 40", led); end
        checks++; if (miss_count !== 4'd1) begin errors++; $display("FAIL mid_miss: got %0d expected 1", miss_count); end
        checks++; if (time_left !== 12'd5) begin errors++; $display("FAIL mid_time: got %0d expected 5", time_left); end
        rst = 1'b1; start = 1'b1; sw = 8'hA5;
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL rst_mid_led: got %h expected 00", led); end
        checks++; if (miss_count !== 4'd0) begin errors++; $display("FAIL rst_mid_miss: got %0d expected 0", miss_count); end
        checks++; if (time_left !== 12'd0) begin errors++; $display("FAIL rst_mid_time: got %0d expected 0", time_left); end
        checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL rst_mid_hit: got %0d expected 0", hit_count); end
        rst = 1'b0; start = 1'b0; rand_byte = 8'h02;
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_rst_idle: got %0d expected 0", state); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(4);
        checks++; if (led !== 8'h04) begin errors++; $display("FAIL post_rst_spawn: got %h expected 04", led); end
        checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL post_rst_no_hit: got %0d expected 0", hit_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_timeout();
        test_single_hit();
        test_miss();
        test_multi_hit();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
